// File: rtl/switch_debounce.sv
// Board slide-switch conditioner: two-flop synchronizer, shared sample tick and
// per-bit stability counters, producing clean levels plus per-bit change pulses.
module switch_debounce #(
  parameter int WIDTH    = 24,
  parameter int TICK_DIV = 100000,
  parameter int DEB_CNT  = 10
) (
  input  logic             swdclk,
  input  logic             swdrst,
  input  logic [WIDTH-1:0] switch_raw,
  output logic [WIDTH-1:0] switch_o,
  output logic [WIDTH-1:0] switch_edge,
  output logic             switch_chg
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_CNT > 0) ? $clog2(DEB_CNT + 1) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [TW-1:0]    tcnt;
  logic             tick;
  logic [DW-1:0]    dcnt     [WIDTH];
  logic [DW-1:0]    dcnt_nxt [WIDTH];
  logic [WIDTH-1:0] swo_nxt;
  logic [WIDTH-1:0] edge_nxt;

  // NOTE: sequential state uses non-blocking assignments so sync2 samples the
  // previous sync1, giving two real flop stages instead of one collapsed wire.
  always_ff @(posedge swdclk or negedge swdrst) begin
    if (!swdrst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switch_raw;
      sync2 <= sync1;
    end
  end

  assign tick = (tcnt == TICK_LAST);

  always_ff @(posedge swdclk or negedge swdrst) begin
    if (!swdrst) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // A matching sample aborts any pending change, tick or not; mismatches only
  // advance on ticks, and acceptance happens on the DEB_CNT-th mismatching tick.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    swo_nxt  = switch_o;
    edge_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dcnt_nxt[i] = dcnt[i];
      if (sync2[i] == switch_o[i]) begin
        dcnt_nxt[i] = '0;
      end else if (tick) begin
        if (dcnt[i] == DEB_LAST) begin
          swo_nxt[i]  = sync2[i];
          dcnt_nxt[i] = '0;
          edge_nxt[i] = 1'b1;
        end else begin
          dcnt_nxt[i] = dcnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge swdclk or negedge swdrst) begin
    if (!swdrst) begin
      switch_o    <= '0;
      switch_edge <= '0;
      switch_chg  <= 1'b0;
      // NOTE: the counter array is reset element by element; a mid-debounce
      // reset must discard progress, so it cannot be left uninitialised.
      for (int i = 0; i < WIDTH; i++) dcnt[i] <= '0;
    end else begin
      switch_o    <= swo_nxt;
      switch_edge <= edge_nxt;
      switch_chg  <= |edge_nxt;
      for (int i = 0; i < WIDTH; i++) dcnt[i] <= dcnt_nxt[i];
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with TICK_DIV=4, DEB_CNT=3; expected
// latencies are hand-derived from the tick phase (tcnt = cycles since release mod 4).
module tb_switch_debounce;

  localparam int W  = 24;
  localparam int TD = 4;
  localparam int DC = 3;

  logic         swdclk = 1'b0;
  logic         swdrst;
  logic [W-1:0] switch_raw;
  logic [W-1:0] switch_o;
  logic [W-1:0] switch_edge;
  logic         switch_chg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  switch_debounce #(.WIDTH(W), .TICK_DIV(TD), .DEB_CNT(DC)) dut (
    .swdclk      (swdclk),
    .swdrst      (swdrst),
    .switch_raw  (switch_raw),
    .switch_o    (switch_o),
    .switch_edge (switch_edge),
    .switch_chg  (switch_chg)
  );

  always #5 swdclk = ~swdclk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge swdclk);
    #1;
    cyc++;
  endtask

  task automatic check_quiet_tick(input logic [W-1:0] exp_o);
    check("switch_o", switch_o, exp_o);
    check("switch_edge", switch_edge, '0);
    check("switch_chg", W'(switch_chg), '0);
    check("tick", W'(dut.tick), W'(cyc % TD == TD - 1));
  endtask

  task automatic hold(input int n, input logic [W-1:0] exp_o);
    for (int k = 0; k < n; k++) begin
      step();
      check_quiet_tick(exp_o);
    end
  endtask

  task automatic expect_update(input logic [W-1:0] exp_o, input logic [W-1:0] exp_edge);
    step();
    check("upd_o", switch_o, exp_o);
    check("upd_edge", switch_edge, exp_edge);
    check("upd_chg", W'(switch_chg), W'(1));
    step();
    check_quiet_tick(exp_o);
  endtask

  initial begin
    // Reset and quiet input
    swdrst     = 1'b0;
    switch_raw = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge swdclk);
      #1;
      check("rst_o", switch_o, '0);
      check("rst_edge", switch_edge, '0);
      check("rst_chg", W'(switch_chg), '0);
    end
    swdrst = 1'b1;
    cyc    = 0;
    hold(50, '0);

    // Clean rise on bit 0: raw set at tcnt=2, lands 14 cycles later
    switch_raw = 24'h000001;
    hold(13, 24'h000000);
    expect_update(24'h000001, 24'h000001);

    // Bounce on bit 5: first sync2 rise at tcnt=2, glitch aborts, re-rise at tcnt=0
    hold(3, 24'h000001);
    switch_raw = 24'h000021;
    hold(9, 24'h000001);
    switch_raw = 24'h000001;
    hold(1, 24'h000001);
    switch_raw = 24'h000021;
    hold(13, 24'h000001);
    expect_update(24'h000021, 24'h000020);

    // Return to zero, then simultaneous multi-bit rise
    switch_raw = 24'h000000;
    hold(10, 24'h000021);
    expect_update(24'h000000, 24'h000021);
    switch_raw = 24'hFF00F0;
    hold(10, 24'h000000);
    expect_update(24'hFF00F0, 24'hFF00F0);

    // Upper nibble falls
    switch_raw = 24'h0F00F0;
    hold(10, 24'hFF00F0);
    expect_update(24'h0F00F0, 24'hF00000);

    // Reset mid-debounce on bit 3
    switch_raw = 24'h0F00F8;
    hold(6, 24'h0F00F0);
    swdrst = 1'b0;
    #1;
    check("midrst_o", switch_o, '0);
    check("midrst_edge", switch_edge, '0);
    check("midrst_chg", W'(switch_chg), '0);
    check("midrst_tcnt", W'(dut.tcnt), '0);
    check("midrst_dcnt3", W'(dut.dcnt[3]), '0);
    @(posedge swdclk);
    #1;
    check("midrst_hold_o", switch_o, '0);
    swdrst = 1'b1;
    cyc    = 0;
    hold(11, 24'h000000);
    expect_update(24'h0F00F8, 24'h0F00F8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Input-conditioning stage between the board's 24 raw slide switches and the switch MMIO read port. It synchronizes each switch into the CPU clock domain, debounces it with a shared sample tick and per-bit stability counters, and drives the clean 24-bit value that the switch port latches on CPU reads. It also emits per-bit change pulses, so later software-visible status logic can detect switch activity without polling.

## Interface
Parameters:
- WIDTH, 24, number of switch bits.
- TICK_DIV, 100000, clock cycles per debounce sample tick (≥2).
- DEB_CNT, 10, consecutive mismatching ticks required to accept a new level (≥1).

Ports:
- swdclk  input  1  system clock. All state updates on the rising edge.
- swdrst  input  1  reset, asynchronous, active-low. Asserting it (0) clears all state immediately.
- switch_raw  input  WIDTH  raw asynchronous board switch levels.
- switch_o  output  WIDTH  debounced switch levels. Connects to the switch port's switch_i.
- switch_edge  output  WIDTH  one-cycle pulse per bit when that bit of switch_o changes.
- switch_chg  output  1  one-cycle pulse, OR of switch_edge.

## Operation
- Synchronizer:
  - Two flops per bit, sync1 <= switch_raw and sync2 <= sync1.
  - Only sync2 is used downstream.
- Tick generator:
  - tcnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (tcnt == TICK_DIV-1), combinational, high for exactly one cycle per TICK_DIV cycles.
- Per-bit stability counter dcnt[i], width clog2(DEB_CNT+1). Each cycle:
  - If sync2[i] == switch_o[i]: dcnt[i] <= 0 in any cycle, tick or not. A single matching sample aborts a pending change.
  - Else if tick and dcnt[i] == DEB_CNT-1: switch_o[i] <= sync2[i], dcnt[i] <= 0, switch_edge[i] <= 1.
  - Else if tick: dcnt[i] <= dcnt[i]+1.
  - Else: hold.
- switch_edge is registered and is 0 in every cycle other than the update cycle.
- switch_chg is registered: it equals the OR of the next-state edge bits, so it is coincident with switch_edge.
- Bits are fully independent. Any number of bits may update on the same tick, and switch_chg stays a single pulse in that case.
- Counters never exceed DEB_CNT-1. There is no overflow or wrap beyond that.

## Timing
- Reset (swdrst=0), asynchronous:
  - sync1, sync2, tcnt, dcnt and switch_o are 0.
  - switch_edge and switch_chg are 0.
  - Switches already high at reset release are accepted after the normal debounce latency and produce an edge pulse.
- Reset asserted mid-debounce discards all progress. After release, tcnt restarts at 0.
- Synchronizer latency: a raw change is visible in sync2 at the 2nd rising edge.
- Debounce latency from the sync2 change to the switch_o change, for a stable input:
  - min (DEB_CNT-1)*TICK_DIV+1 cycles, max DEB_CNT*TICK_DIV cycles.
  - The exact value depends on tcnt phase.
- With tcnt=0 at the cycle sync2 changes, the change lands exactly DEB_CNT*TICK_DIV cycles later. This holds because tick occurs in the cycle where tcnt = TICK_DIV-1, and the update takes effect at the rising edge ending that cycle.
- switch_edge and switch_chg rise in the same cycle switch_o changes and last exactly 1 cycle.
- A bounce shorter than one tick period may go unseen, because samples are only counted at ticks. This is by design.
- No handshake: switch_o is level data, and the consumer samples it freely on its own edge.

## Test plan
1. Reset and quiet input (TICK_DIV=4, DEB_CNT=3). Hold swdrst=0 for 3 cycles with switch_raw=0, then release with input 0 for 50 cycles.
   - Required: switch_o=0, switch_edge=0 and switch_chg=0 throughout.
   - Required: tick every 4th cycle.
2. Clean rise on bit 0. Release reset, then set switch_raw=24'h000001 at the cycle where tcnt=2, so sync2 changes when tcnt=0.
   - Required: switch_o becomes 24'h000001 exactly 2+12 cycles after the raw change.
   - Required: switch_edge=24'h000001 and switch_chg=1 for one cycle.
3. Bounce rejection. Raw bit 5 high for 9 cycles, low for 1 cycle, then high and held.
   - Required: no change until 12 cycles after the last sync2 rise.
   - Required: exactly one edge pulse.
4. Simultaneous bits. switch_raw 0 -> 24'hFF00F0 in one cycle.
   - Required: switch_o becomes 24'hFF00F0 in a single cycle.
   - Required: switch_edge=24'hFF00F0 and switch_chg is high for 1 cycle only.
5. Fall and upper byte. From 24'hFF00F0, set raw to 24'h0F00F0.
   - Required: after the debounce latency, switch_o=24'h0F00F0 and switch_edge=24'hF00000 for one cycle.
6. Reset mid-debounce. Change raw bit 3, wait 6 cycles, pulse swdrst low for 1 cycle.
   - Required: switch_o clears immediately and all counters restart.
   - Required: the bit 3 update lands a full debounce latency after release, within the min..max window.
